// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the MEM-stage data-memory access sequencer.
// Holds the load/store opcode encodings, bus size codes, FSM state encodings
// and the load-extension helper used by mem_lane_fmt.
package mem_access_ctrl_pkg;

    localparam int unsigned DataW = 32;
    localparam int unsigned OpW   = 6;
    localparam int unsigned SizeW = 2;

    // Load/store opcodes (MIPS I encodings)
    localparam logic [OpW-1:0] OP_LB  = 6'b100000;
    localparam logic [OpW-1:0] OP_LH  = 6'b100001;
    localparam logic [OpW-1:0] OP_LW  = 6'b100011;
    localparam logic [OpW-1:0] OP_LBU = 6'b100100;
    localparam logic [OpW-1:0] OP_LHU = 6'b100101;
    localparam logic [OpW-1:0] OP_SB  = 6'b101000;
    localparam logic [OpW-1:0] OP_SH  = 6'b101001;
    localparam logic [OpW-1:0] OP_SW  = 6'b101011;

    // Bus transfer size codes
    localparam logic [SizeW-1:0] SZ_BYTE = 2'd0;
    localparam logic [SizeW-1:0] SZ_HALF = 2'd1;
    localparam logic [SizeW-1:0] SZ_WORD = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_DATA  = 3'd2,
        ST_DONE  = 3'd3,
        ST_DRAIN = 3'd4
    } memState_t;

    // Extend the lane already shifted down to bit 0 according to access size.
    function automatic logic [DataW-1:0] loadExtend(
        input logic [DataW-1:0] laneData,
        input logic [SizeW-1:0] size,
        input logic             sgn
    );
        logic [DataW-1:0] r;
        case (size)
            SZ_BYTE: r = {{24{sgn & laneData[7]}}, laneData[7:0]};
            SZ_HALF: r = {{16{sgn & laneData[15]}}, laneData[15:0]};
            default: r = laneData;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_lane_fmt.sv
// Combinational lane formatter for data-memory accesses.
// Decodes load/store opcode into size/direction, flags misalignment,
// replicates store data across byte lanes and extends load data.
// Ports:
//   opM          in   opcode of the MEM-stage instruction
//   addrLo       in   effective address bits [1:0]
//   wdata        in   raw store data (rt)
//   rdata        in   raw bus read data
//   isLoad_c     out  opcode is LB/LBU/LH/LHU/LW
//   isStore_c    out  opcode is SB/SH/SW
//   misaligned_c out  load/store address not aligned to its size
//   size_c       out  bus size code
//   wdataFmt_c   out  lane-replicated store data
//   rdataExt_c   out  selected and extended load result
module mem_lane_fmt
    import mem_access_ctrl_pkg::*;
(
    input  logic [OpW-1:0]   opM,
    input  logic [1:0]       addrLo,
    input  logic [DataW-1:0] wdata,
    input  logic [DataW-1:0] rdata,
    output logic             isLoad_c,
    output logic             isStore_c,
    output logic             misaligned_c,
    output logic [SizeW-1:0] size_c,
    output logic [DataW-1:0] wdataFmt_c,
    output logic [DataW-1:0] rdataExt_c
);

    logic             sgnExt;
    logic [DataW-1:0] laneData;

    // Opcode decode
    always_comb begin
        isLoad_c  = 1'b0;
        isStore_c = 1'b0;
        size_c    = SZ_WORD;
        sgnExt    = 1'b0;
        case (opM)
            OP_LB:  begin isLoad_c  = 1'b1; size_c = SZ_BYTE; sgnExt = 1'b1; end
            OP_LBU: begin isLoad_c  = 1'b1; size_c = SZ_BYTE; end
            OP_LH:  begin isLoad_c  = 1'b1; size_c = SZ_HALF; sgnExt = 1'b1; end
            OP_LHU: begin isLoad_c  = 1'b1; size_c = SZ_HALF; end
            OP_LW:  begin isLoad_c  = 1'b1; size_c = SZ_WORD; end
            OP_SB:  begin isStore_c = 1'b1; size_c = SZ_BYTE; end
            OP_SH:  begin isStore_c = 1'b1; size_c = SZ_HALF; end
            OP_SW:  begin isStore_c = 1'b1; size_c = SZ_WORD; end
            default: ;
        endcase
    end

    assign misaligned_c = (isLoad_c | isStore_c) &
                          (((size_c == SZ_HALF) & addrLo[0]) |
                           ((size_c == SZ_WORD) & (|addrLo)));

    // Store lane replication
    always_comb begin
        case (size_c)
            SZ_BYTE: wdataFmt_c = {4{wdata[7:0]}};
            SZ_HALF: wdataFmt_c = {2{wdata[15:0]}};
            default: wdataFmt_c = wdata;
        endcase
    end

    // Bring the addressed lane down to bit 0 (little-endian lanes)
    assign laneData   = rdata >> {addrLo, 3'b000};
    assign rdataExt_c = loadExtend(laneData, size_c, sgnExt);

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer.
// Checks alignment, issues one bus transaction per legal load/store, formats
// store lanes / load extension and stalls the pipeline until the access retires.
// Optional abort timer enabled by defining MEM_ACC_TIMEOUT_EN (parameter
// TIMEOUT_CYCLES only exists in that build).
// Ports:
//   clk, resetn                  clock, async active-low reset
//   req_valid, opM, addr, wdata  MEM-stage load/store request
//   flush, ext_stall             pipeline flush / hold from other sources
//   stall_o                      hold IF..MEM while the access is not retired
//   rdata_o                      extended load result, valid in DONE
//   adelM, adesM                 load/store address error (combinational)
//   bus_err_o                    one-cycle pulse on timeout abort
//   data_req..data_wdata         bus request channel
//   data_addr_ok, data_data_ok, data_rdata  bus response channel
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
`ifdef MEM_ACC_TIMEOUT_EN
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
)
`endif
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             req_valid,
    input  logic [OpW-1:0]   opM,
    input  logic [DataW-1:0] addr,
    input  logic [DataW-1:0] wdata,
    input  logic             flush,
    input  logic             ext_stall,
    output logic             stall_o,
    output logic [DataW-1:0] rdata_o,
    output logic             adelM,
    output logic             adesM,
    output logic             bus_err_o,
    output logic             data_req,
    output logic             data_wr,
    output logic [SizeW-1:0] data_size,
    output logic [DataW-1:0] data_addr,
    output logic [DataW-1:0] data_wdata,
    input  logic             data_addr_ok,
    input  logic             data_data_ok,
    input  logic [DataW-1:0] data_rdata
);

    memState_t        state;
    memState_t        stateNext;
    logic             isLoad;
    logic             isStore;
    logic             misaligned;
    logic [SizeW-1:0] accSize;
    logic [DataW-1:0] wdataFmt;
    logic [DataW-1:0] rdataExt;
    logic             start;
    logic             dataReq;
    logic             captureLd;
    logic             abort;
    logic             timeoutHit;

    mem_lane_fmt uLaneFmt (
        .opM          (opM),
        .addrLo       (addr[1:0]),
        .wdata        (wdata),
        .rdata        (data_rdata),
        .isLoad_c     (isLoad),
        .isStore_c    (isStore),
        .misaligned_c (misaligned),
        .size_c       (accSize),
        .wdataFmt_c   (wdataFmt),
        .rdataExt_c   (rdataExt)
    );

    // Address errors are not gated by flush: flush is derived from them.
    assign adelM = req_valid & isLoad  & misaligned;
    assign adesM = req_valid & isStore & misaligned;

    assign start = (state == ST_IDLE) & req_valid & (isLoad | isStore) & ~misaligned & ~flush;

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= stateNext;
    end

    // Next-state and bus request. The request is already on the bus in the
    // IDLE cycle, so a same-cycle addr_ok/data_ok must be honoured there.
    always_comb begin
        stateNext = state;
        dataReq   = 1'b0;
        captureLd = 1'b0;
        abort     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    dataReq = 1'b1;
                    if (data_addr_ok & data_data_ok) begin
                        stateNext = ST_DONE;
                        captureLd = isLoad;
                    end else if (data_addr_ok) begin
                        stateNext = ST_DATA;
                    end else begin
                        stateNext = ST_ADDR;
                    end
                end
            end
            ST_ADDR: begin
                dataReq = 1'b1;
                if (flush) begin
                    // Accepted but unanswered transactions must still be drained
                    stateNext = (data_addr_ok & ~data_data_ok) ? ST_DRAIN : ST_IDLE;
                end else if (data_addr_ok & data_data_ok) begin
                    stateNext = ST_DONE;
                    captureLd = isLoad;
                end else if (data_addr_ok) begin
                    stateNext = ST_DATA;
                end else if (timeoutHit) begin
                    stateNext = ST_DONE;
                    abort     = 1'b1;
                end
            end
            ST_DATA: begin
                if (flush) begin
                    stateNext = data_data_ok ? ST_IDLE : ST_DRAIN;
                end else if (data_data_ok) begin
                    stateNext = ST_DONE;
                    captureLd = isLoad;
                end else if (timeoutHit) begin
                    stateNext = ST_DONE;
                    abort     = 1'b1;
                end
            end
            ST_DONE: begin
                if (flush | ~ext_stall) stateNext = ST_IDLE;
            end
            ST_DRAIN: begin
                if (data_data_ok) stateNext = ST_IDLE;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // Load result register; cleared on abort, untouched by stores and drains
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)        rdata_o <= '0;
        else if (captureLd) rdata_o <= rdataExt;
        else if (abort)     rdata_o <= '0;
    end

`ifdef MEM_ACC_TIMEOUT_EN
    localparam int unsigned CntW = 8;

    logic [CntW-1:0] toCnt;
    logic            busErrQ;

    // Cycles spent in ADDR/DATA for the current access
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                                     toCnt <= '0;
        else if (start)                                  toCnt <= '0;
        else if ((state == ST_ADDR) | (state == ST_DATA)) toCnt <= toCnt + CntW'(1);
    end

    assign timeoutHit = (toCnt == CntW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) busErrQ <= 1'b0;
        else         busErrQ <= abort;
    end

    assign bus_err_o = busErrQ;
`else
    assign timeoutHit = 1'b0;
    assign bus_err_o  = 1'b0;
`endif

    assign stall_o    = (state == ST_ADDR) | (state == ST_DATA) | (state == ST_DRAIN) | start;
    assign data_req   = dataReq;
    assign data_wr    = isStore;
    assign data_size  = accSize;
    assign data_addr  = addr;
    assign data_wdata = wdataFmt;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: the stimulus process pushes the
// expected bus request / exception / retirement events, a monitor pops and
// compares them as the DUT presents them.
`timescale 1ns/1ps
module tb_mem_access_ctrl;
    import mem_access_ctrl_pkg::*;

    localparam int EvReq = 0;
    localparam int EvExc = 1;
    localparam int EvRet = 2;

    typedef struct {
        int          kind;
        string       name;
        logic [31:0] v0;
        logic [31:0] v1;
        logic [31:0] v2;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        reqValid;
    logic [5:0]  opM;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        flush;
    logic        extStall;
    logic        stallO;
    logic [31:0] rdataO;
    logic        adelM;
    logic        adesM;
    logic        busErr;
    logic        dataReq;
    logic        dataWr;
    logic [1:0]  dataSize;
    logic [31:0] dataAddr;
    logic [31:0] dataWdata;
    logic        addrOk;
    logic        dataOk;
    logic [31:0] dataRdata;

    exp_t expQ[$];
    int   nTests = 0;
    int   nFail  = 0;
    bit   stimDone = 1'b0;

    always #5 clk = ~clk;

`ifdef MEM_ACC_TIMEOUT_EN
    mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (reqValid),
        .opM          (opM),
        .addr         (addr),
        .wdata        (wdata),
        .flush        (flush),
        .ext_stall    (extStall),
        .stall_o      (stallO),
        .rdata_o      (rdataO),
        .adelM        (adelM),
        .adesM        (adesM),
        .bus_err_o    (busErr),
        .data_req     (dataReq),
        .data_wr      (dataWr),
        .data_size    (dataSize),
        .data_addr    (dataAddr),
        .data_wdata   (dataWdata),
        .data_addr_ok (addrOk),
        .data_data_ok (dataOk),
        .data_rdata   (dataRdata)
    );
`else
    mem_access_ctrl dut (
        .clk          (clk),
        .resetn       (resetn),
        .req_valid    (reqValid),
        .opM          (opM),
        .addr         (addr),
        .wdata        (wdata),
        .flush        (flush),
        .ext_stall    (extStall),
        .stall_o      (stallO),
        .rdata_o      (rdataO),
        .adelM        (adelM),
        .adesM        (adesM),
        .bus_err_o    (busErr),
        .data_req     (dataReq),
        .data_wr      (dataWr),
        .data_size    (dataSize),
        .data_addr    (dataAddr),
        .data_wdata   (dataWdata),
        .data_addr_ok (addrOk),
        .data_data_ok (dataOk),
        .data_rdata   (dataRdata)
    );
`endif

    function automatic void pushExp(input int kind, input string name,
                                    input logic [31:0] v0, input logic [31:0] v1,
                                    input logic [31:0] v2);
        exp_t e;
        e.kind = kind;
        e.name = name;
        e.v0   = v0;
        e.v1   = v1;
        e.v2   = v2;
        expQ.push_back(e);
    endfunction

    task automatic check(input string name, input string field,
                         input logic [31:0] act, input logic [31:0] req);
        nTests++;
        if (act !== req) begin
            nFail++;
            $display("FAIL %s.%s: got 0x%08h, required 0x%08h", name, field, act, req);
        end
    endtask

    task automatic popExp(input int kind, output exp_t e, output bit ok);
        ok = 1'b0;
        nTests++;
        if (expQ.size() == 0) begin
            nFail++;
            $display("FAIL unexpected_event: got event kind %0d, required none", kind);
        end else begin
            e = expQ.pop_front();
            if (e.kind != kind) begin
                nFail++;
                $display("FAIL %s.kind: got event kind %0d, required %0d", e.name, kind, e.kind);
            end else begin
                ok = 1'b1;
            end
        end
    endtask

    // Monitor / scoreboard
    initial begin : monitor
        exp_t e;
        bit   ok;
        bit   prevReq;
        bit   busy;
        int   stallCnt;
        int   cycles;
        prevReq  = 1'b0;
        busy     = 1'b0;
        stallCnt = 0;
        cycles   = 0;
        @(negedge clk);
        check("reset", "stall_o",   32'(stallO),  32'h0);
        check("reset", "data_req",  32'(dataReq), 32'h0);
        check("reset", "rdata_o",   rdataO,       32'h0);
        check("reset", "bus_err_o", 32'(busErr),  32'h0);
        forever begin
            @(negedge clk);
            if (stimDone) break;
            cycles++;
            if (cycles > 20000) begin
                nTests++;
                nFail++;
                $display("FAIL watchdog: got %0d cycles, required completion", cycles);
                break;
            end
            if (dataReq && !prevReq) begin
                popExp(EvReq, e, ok);
                if (ok) begin
                    check(e.name, "wr_size", {29'd0, dataWr, dataSize}, e.v0);
                    check(e.name, "addr",    dataAddr,  e.v1);
                    check(e.name, "wdata",   dataWdata, e.v2);
                end
                busy     = 1'b1;
                stallCnt = 0;
            end
            if (adelM || adesM) begin
                popExp(EvExc, e, ok);
                if (ok) check(e.name, "adel_ades_req_stall",
                              {28'd0, adelM, adesM, dataReq, stallO}, e.v0);
            end
            if (busy) begin
                if (stallO) begin
                    stallCnt++;
                end else begin
                    popExp(EvRet, e, ok);
                    if (ok) begin
                        check(e.name, "rdata_o",     rdataO,          e.v0);
                        check(e.name, "stall_cycles", 32'(stallCnt),  e.v1);
                        check(e.name, "req_buserr",  {30'd0, dataReq, busErr}, e.v2);
                    end
                    busy = 1'b0;
                end
            end
            prevReq = dataReq;
        end
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            nTests++;
            nFail++;
            $display("FAIL %s.missing: got no event kind %0d, required one", e.name, e.kind);
        end
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    // One legal access; all timing handshakes given explicitly.
    task automatic access(input string name, input logic [5:0] op, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd,
                          input int waitAddr, input int waitData, input bit together,
                          input int hold, input logic expWr, input logic [1:0] expSize,
                          input logic [31:0] expWd, input logic [31:0] expRd,
                          input int expStalls);
        pushExp(EvReq, name, {29'd0, expWr, expSize}, a, expWd);
        pushExp(EvRet, name, expRd, 32'(expStalls), 32'h0);
        reqValid = 1'b1;
        opM      = op;
        addr     = a;
        wdata    = wd;
        repeat (waitAddr) begin @(posedge clk); #1; end
        addrOk = 1'b1;
        if (together) begin
            dataOk    = 1'b1;
            dataRdata = rd;
        end
        @(posedge clk); #1;
        addrOk = 1'b0;
        if (!together) begin
            repeat (waitData) begin @(posedge clk); #1; end
            dataOk    = 1'b1;
            dataRdata = rd;
            @(posedge clk); #1;
        end
        dataOk   = 1'b0;
        extStall = (hold > 0);
        repeat (hold) begin @(posedge clk); #1; end
        extStall = 1'b0;
        @(posedge clk); #1;
        reqValid = 1'b0;
    endtask

    task automatic misalign(input string name, input logic [5:0] op,
                            input logic [31:0] a, input logic [3:0] expBits);
        pushExp(EvExc, name, {28'd0, expBits}, 32'h0, 32'h0);
        reqValid = 1'b1;
        opM      = op;
        addr     = a;
        @(posedge clk); #1;
        reqValid = 1'b0;
        @(posedge clk); #1;
    endtask

    // Stimulus
    initial begin : stim
        resetn    = 1'b0;
        reqValid  = 1'b0;
        opM       = '0;
        addr      = '0;
        wdata     = '0;
        flush     = 1'b0;
        extStall  = 1'b0;
        addrOk    = 1'b0;
        dataOk    = 1'b0;
        dataRdata = '0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;

        access("lw_basic", OP_LW, 32'h1000, 32'h0, 32'h8899AABB, 0, 0, 0, 0,
               1'b0, SZ_WORD, 32'h0, 32'h8899AABB, 2);
        access("lb_sext", OP_LB, 32'h1003, 32'h0, 32'h80FFFF12, 0, 0, 0, 0,
               1'b0, SZ_BYTE, 32'h0, 32'hFFFFFF80, 2);
        access("lbu_zext_hold", OP_LBU, 32'h1003, 32'h0, 32'h80FFFF12, 0, 0, 0, 2,
               1'b0, SZ_BYTE, 32'h0, 32'h00000080, 2);
        access("sh_lanes", OP_SH, 32'h2002, 32'h1234ABCD, 32'h5555AAAA, 0, 0, 0, 0,
               1'b1, SZ_HALF, 32'hABCDABCD, 32'h00000080, 2);
        access("lh_waits", OP_LH, 32'h1000, 32'h0, 32'h9ABC8765, 1, 2, 0, 0,
               1'b0, SZ_HALF, 32'h0, 32'hFFFF8765, 5);
        access("lhu_same_cycle", OP_LHU, 32'h1002, 32'h0, 32'h9ABC1234, 0, 0, 1, 0,
               1'b0, SZ_HALF, 32'h0, 32'h00009ABC, 1);
        access("sb_lanes", OP_SB, 32'h4001, 32'h000000A5, 32'h5555AAAA, 2, 0, 1, 0,
               1'b1, SZ_BYTE, 32'hA5A5A5A5, 32'h00009ABC, 3);
        access("sw_word", OP_SW, 32'h4004, 32'hCAFEF00D, 32'h5555AAAA, 0, 1, 0, 0,
               1'b1, SZ_WORD, 32'hCAFEF00D, 32'h00009ABC, 3);

        misalign("lw_adel", OP_LW, 32'h1002, 4'b1000);
        misalign("sh_ades", OP_SH, 32'h3001, 4'b0100);

        // Flush in DATA; data_ok 3 cycles later is drained and discarded
        pushExp(EvReq, "flush_data", {29'd0, 1'b0, SZ_WORD}, 32'h1000, 32'h0);
        pushExp(EvRet, "flush_data", 32'h00009ABC, 32'd5, 32'h0);
        reqValid = 1'b1; opM = OP_LW; addr = 32'h1000; wdata = 32'h0; addrOk = 1'b1;
        @(posedge clk); #1;
        addrOk = 1'b0; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; reqValid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        dataOk = 1'b1; dataRdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        dataOk = 1'b0;
        @(posedge clk); #1;

        // Flush in ADDR before addr_ok; stray data_ok in IDLE afterwards
        pushExp(EvReq, "flush_addr", {29'd0, 1'b0, SZ_WORD}, 32'h1004, 32'h0);
        pushExp(EvRet, "flush_addr", 32'h00009ABC, 32'd2, 32'h0);
        reqValid = 1'b1; opM = OP_LW; addr = 32'h1004;
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; reqValid = 1'b0; dataOk = 1'b1; dataRdata = 32'hFEEDFACE;
        @(posedge clk); #1;
        dataOk = 1'b0;
        @(posedge clk); #1;

        access("lw_recover", OP_LW, 32'h1008, 32'h0, 32'h11223344, 0, 0, 0, 0,
               1'b0, SZ_WORD, 32'h0, 32'h11223344, 2);

`ifdef MEM_ACC_TIMEOUT_EN
        // addr_ok never comes: abort after 4 cycles in ADDR, then hold DONE
        pushExp(EvReq, "timeout", {29'd0, 1'b0, SZ_WORD}, 32'h100C, 32'h0);
        pushExp(EvRet, "timeout", 32'h0, 32'd5, 32'h1);
        reqValid = 1'b1; opM = OP_LW; addr = 32'h100C; addrOk = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        extStall = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        extStall = 1'b0;
        @(posedge clk); #1;
        reqValid = 1'b0;
`endif

        repeat (3) @(posedge clk);
        stimDone = 1'b1;
    end

endmodule
